// File: rtl/lock_pkg.sv
// Shared state encodings and default timing constants for the lock controller
// and the setting/checking blocks built around it.
package lock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETTING  = 3'd1,
    ST_CHECKING = 3'd2,
    ST_VERDICT  = 3'd3,
    ST_OPEN     = 3'd4,
    ST_LOCKOUT  = 3'd5,
    ST_ALARM    = 3'd6,
    ST_UNUSED   = 3'd7
  } state_t;

  localparam logic [31:0] DEF_TIMEOUT_CYCLES = 32'd500_000_000;
  localparam logic [31:0] DEF_LOCKOUT_CYCLES = 32'd100_000_000;
  localparam logic [31:0] DEF_OPEN_CYCLES    = 32'd250_000_000;
  localparam logic [1:0]  DEF_MAX_TRIES      = 2'd3;
  localparam logic [3:0]  DEF_VERDICT_WAIT   = 4'd8;

endpackage

// File: rtl/edge_pulse.sv
// Rising-edge detector on a debounced button level. Edges are masked for the
// first cycle after reset so a button held through reset release never fires.
module edge_pulse (
  input  logic clk,
  input  logic rst,
  input  logic lvl,
  output logic rise
);

  logic prev;
  logic armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev  <= 1'b0;
      armed <= 1'b0;
    end else begin
      prev  <= lvl;
      armed <= 1'b1;
    end
  end

  assign rise = armed & lvl & ~prev;

endmodule

// File: rtl/lock_controller.sv
// Door lock sequencing FSM: button edges and keypad strobes in, one-cycle
// command pulses to the set/check datapath and registered lock status out.
module lock_controller
  import lock_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter logic [31:0] LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
  parameter logic [31:0] OPEN_CYCLES    = DEF_OPEN_CYCLES,
  parameter logic [1:0]  MAX_TRIES      = DEF_MAX_TRIES,
  parameter logic [3:0]  VERDICT_WAIT   = DEF_VERDICT_WAIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_set,
  input  logic       btn_check,
  input  logic       btn_confirm,
  input  logic       key_en,
  input  logic       ok_i,
  input  logic       bad_i,
  output logic       set_p,
  output logic       check_p,
  output logic       confirm_p,
  output logic [2:0] mode,
  output logic [1:0] tries,
  output logic       unlocked,
  output logic       locked_out,
  output logic       alarm
);

  function automatic logic [1:0] sat_inc(input logic [1:0] v);
    return (v >= MAX_TRIES) ? MAX_TRIES : v + 2'd1;
  endfunction

  state_t      state, state_d;
  logic [1:0]  tries_q, tries_d, tries_inc;
  logic        pw_valid, pw_valid_d;
  logic [31:0] timer, limit;
  logic        key_zone, expire, bad;
  logic        set_e, check_e, confirm_e;
  logic        set_d, check_d, confirm_d;
  logic        unlocked_d, locked_out_d, alarm_d;

  edge_pulse u_set_edge     (.clk(clk), .rst(rst), .lvl(btn_set),     .rise(set_e));
  edge_pulse u_check_edge   (.clk(clk), .rst(rst), .lvl(btn_check),   .rise(check_e));
  edge_pulse u_confirm_edge (.clk(clk), .rst(rst), .lvl(btn_confirm), .rise(confirm_e));

  // Per-state timer limit; IDLE and ALARM never expire.
  always_comb begin
    limit = 32'd0;
    case (state)
      ST_SETTING, ST_CHECKING: limit = TIMEOUT_CYCLES;
      ST_VERDICT:              limit = {28'd0, VERDICT_WAIT};
      ST_OPEN:                 limit = OPEN_CYCLES;
      ST_LOCKOUT:              limit = LOCKOUT_CYCLES;
      default:                 limit = 32'd0;
    endcase
  end

  assign key_zone  = (state == ST_SETTING) || (state == ST_CHECKING);
  assign expire    = (limit != 32'd0) && (timer == limit - 32'd1) && !(key_zone && key_en);
  assign tries_inc = sat_inc(tries_q);

  always_comb begin
    state_d    = state;
    tries_d    = tries_q;
    pw_valid_d = pw_valid;
    set_d      = 1'b0;
    check_d    = 1'b0;
    confirm_d  = 1'b0;
    bad        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (set_e && !pw_valid) begin
          state_d = ST_SETTING;
          set_d   = 1'b1;
        end else if (check_e && pw_valid) begin
          state_d = ST_CHECKING;
          check_d = 1'b1;
        end
      end
      ST_SETTING: begin
        if (confirm_e) begin
          state_d    = ST_IDLE;
          confirm_d  = 1'b1;
          pw_valid_d = 1'b1;
        end else if (expire) begin
          state_d = ST_IDLE;
        end
      end
      ST_CHECKING: begin
        if (confirm_e) begin
          state_d   = ST_VERDICT;
          confirm_d = 1'b1;
        end else if (expire) begin
          bad = 1'b1;
        end
      end
      ST_VERDICT: begin
        if (bad_i) begin
          bad = 1'b1;
        end else if (ok_i) begin
          state_d = ST_OPEN;
          tries_d = 2'd0;
        end else if (expire) begin
          bad = 1'b1;
        end
      end
      ST_OPEN: begin
        if (set_e) begin
          state_d = ST_SETTING;
          set_d   = 1'b1;
        end else if (expire) begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCKOUT: if (expire) state_d = ST_IDLE;
      ST_ALARM:   state_d = ST_ALARM;
      default:    state_d = ST_IDLE;
    endcase
    // Every bad verdict source funnels through here so tries and alarm are handled once.
    if (bad) begin
      tries_d = tries_inc;
      state_d = (tries_inc == MAX_TRIES) ? ST_ALARM : ST_LOCKOUT;
    end
  end

  always_comb begin
    unlocked_d   = (state_d == ST_OPEN);
    locked_out_d = (state_d == ST_LOCKOUT);
    alarm_d      = (state_d == ST_ALARM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      tries_q    <= 2'd0;
      pw_valid   <= 1'b0;
      timer      <= 32'd0;
      set_p      <= 1'b0;
      check_p    <= 1'b0;
      confirm_p  <= 1'b0;
      mode       <= 3'd0;
      unlocked   <= 1'b0;
      locked_out <= 1'b0;
      alarm      <= 1'b0;
    end else begin
      state      <= state_d;
      tries_q    <= tries_d;
      pw_valid   <= pw_valid_d;
      set_p      <= set_d;
      check_p    <= check_d;
      confirm_p  <= confirm_d;
      mode       <= state_d;
      unlocked   <= unlocked_d;
      locked_out <= locked_out_d;
      alarm      <= alarm_d;
      if ((state_d != state) || (key_zone && key_en)) timer <= 32'd0;
      else                                            timer <= timer + 32'd1;
    end
  end

  assign tries = tries_q;

endmodule

// File: tb/tb_lock_controller.sv
// Directed bench for lock_controller with a countdown-based reference model
// compared against every output on every falling clock edge.
module tb_lock_controller;

  localparam logic [31:0] P_TIMEOUT = 32'd20;
  localparam logic [31:0] P_LOCKOUT = 32'd10;
  localparam logic [31:0] P_OPEN    = 32'd15;
  localparam logic [3:0]  P_VWAIT   = 4'd8;
  localparam logic [1:0]  P_MAXTRY  = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_set = 1'b0, btn_check = 1'b0, btn_confirm = 1'b0;
  logic key_en = 1'b0, ok_i = 1'b0, bad_i = 1'b0;
  logic set_p, check_p, confirm_p;
  logic [2:0] mode;
  logic [1:0] tries;
  logic unlocked, locked_out, alarm;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lock_controller #(
    .TIMEOUT_CYCLES(P_TIMEOUT), .LOCKOUT_CYCLES(P_LOCKOUT), .OPEN_CYCLES(P_OPEN),
    .MAX_TRIES(P_MAXTRY), .VERDICT_WAIT(P_VWAIT)
  ) dut (
    .clk(clk), .rst(rst), .btn_set(btn_set), .btn_check(btn_check),
    .btn_confirm(btn_confirm), .key_en(key_en), .ok_i(ok_i), .bad_i(bad_i),
    .set_p(set_p), .check_p(check_p), .confirm_p(confirm_p), .mode(mode),
    .tries(tries), .unlocked(unlocked), .locked_out(locked_out), .alarm(alarm)
  );

  // Reference model: state number, remaining cycles before the state's deadline.
  int       m_state = 0, m_tries = 0, m_left = 0;
  bit       m_pw = 0, m_armed = 0, m_valid = 0;
  bit       m_sp = 0, m_cp = 0, m_fp = 0;
  logic [2:0] m_prev = 3'b000;

  function automatic int lim(input int s);
    case (s)
      1, 2:    return 20;
      3:       return 8;
      4:       return 15;
      5:       return 10;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk) begin
    int nxt;
    bit se, ce, fe, keyz, expd, bad;
    if (rst) begin
      m_state = 0; m_tries = 0; m_left = 0; m_pw = 0; m_armed = 0;
      m_prev = 3'b000; m_sp = 0; m_cp = 0; m_fp = 0; m_valid = 1;
    end else if (m_valid) begin
      se = m_armed && btn_set && !m_prev[0];
      ce = m_armed && btn_check && !m_prev[1];
      fe = m_armed && btn_confirm && !m_prev[2];
      m_prev = {btn_confirm, btn_check, btn_set};
      m_armed = 1;
      keyz = (m_state == 1) || (m_state == 2);
      expd = (m_left == 1) && !(keyz && key_en);
      nxt = m_state; bad = 0; m_sp = 0; m_cp = 0; m_fp = 0;
      case (m_state)
        0: if (se && !m_pw) begin nxt = 1; m_sp = 1; end
           else if (ce && m_pw) begin nxt = 2; m_cp = 1; end
        1: if (fe) begin nxt = 0; m_fp = 1; m_pw = 1; end
           else if (expd) nxt = 0;
        2: if (fe) begin nxt = 3; m_fp = 1; end
           else if (expd) bad = 1;
        3: if (bad_i || (!ok_i && expd)) bad = 1;
           else if (ok_i) begin nxt = 4; m_tries = 0; end
        4: if (se) begin nxt = 1; m_sp = 1; end
           else if (expd) nxt = 0;
        5: if (expd) nxt = 0;
        default: ;
      endcase
      if (bad) begin
        m_tries = (m_tries < 3) ? m_tries + 1 : 3;
        nxt = (m_tries == 3) ? 6 : 5;
      end
      if (nxt != m_state) m_left = lim(nxt);
      else if (keyz && key_en) m_left = 20;
      else if (m_left > 0) m_left--;
      m_state = nxt;
    end
  end

  function automatic logic [10:0] exp_vec();
    logic [2:0] s;
    logic [1:0] t;
    s = m_state[2:0];
    t = m_tries[1:0];
    return {s, t, m_state == 4, m_state == 5, m_state == 6, m_sp, m_cp, m_fp};
  endfunction

  always @(negedge clk) begin
    if (m_valid) begin
      checks++;
      if ({mode, tries, unlocked, locked_out, alarm, set_p, check_p, confirm_p} !== exp_vec()) begin
        failures++;
        $display("FAIL model_cmp t=%0t actual=%b required=%b", $time,
                 {mode, tries, unlocked, locked_out, alarm, set_p, check_p, confirm_p}, exp_vec());
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int which);
    case (which)
      0:       btn_set = 1'b1;
      1:       btn_check = 1'b1;
      default: btn_confirm = 1'b1;
    endcase
    tick(1);
    btn_set = 1'b0; btn_check = 1'b0; btn_confirm = 1'b0;
  endtask

  task automatic key(input int n);
    key_en = 1'b1;
    tick(n);
    key_en = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_tries", 32'(tries), 32'd0);
    chk("rst_alarm", 32'(alarm), 32'd0);
    chk("rst_set_p", 32'(set_p), 32'd0);
    tick(2);

    // Check without a password is ignored.
    press(1);
    chk("nopw_check_p", 32'(check_p), 32'd0);
    chk("nopw_mode", 32'(mode), 32'd0);

    // Program a password.
    press(0);
    chk("set_pulse", 32'(set_p), 32'd1);
    chk("set_mode", 32'(mode), 32'd1);
    tick(1);
    chk("set_pulse_end", 32'(set_p), 32'd0);
    key(3);
    press(2);
    chk("cfm_pulse", 32'(confirm_p), 32'd1);
    chk("cfm_mode", 32'(mode), 32'd0);
    press(0);
    chk("set_ignored_pw", 32'(mode), 32'd0);

    // Successful check, 15-cycle open window.
    press(1);
    chk("chk_mode", 32'(mode), 32'd2);
    press(2);
    chk("verdict_mode", 32'(mode), 32'd3);
    tick(1);
    ok_i = 1'b1;
    tick(1);
    ok_i = 1'b0;
    chk("open_mode", 32'(mode), 32'd4);
    chk("open_unlocked", 32'(unlocked), 32'd1);
    tick(14);
    chk("open_last", 32'(mode), 32'd4);
    tick(1);
    chk("open_relock", 32'(mode), 32'd0);
    chk("open_tries", 32'(tries), 32'd0);

    // Password change from OPEN; check edge ignored there.
    press(1);
    press(2);
    ok_i = 1'b1;
    tick(1);
    ok_i = 1'b0;
    press(1);
    chk("open_chk_ign", 32'(check_p), 32'd0);
    chk("open_chk_mode", 32'(mode), 32'd4);
    press(0);
    chk("open_set_mode", 32'(mode), 32'd1);
    chk("open_set_p", 32'(set_p), 32'd1);
    press(2);
    chk("chg_cfm_mode", 32'(mode), 32'd0);

    // Three bad verdicts end in alarm.
    for (int i = 1; i <= 3; i++) begin
      press(1);
      press(2);
      bad_i = 1'b1;
      tick(1);
      bad_i = 1'b0;
      chk("bad_tries", 32'(tries), 32'(i));
      if (i < 3) begin
        chk("bad_lockout", 32'(locked_out), 32'd1);
        tick(9);
        chk("lockout_last", 32'(mode), 32'd5);
        tick(1);
        chk("lockout_end", 32'(mode), 32'd0);
      end else begin
        chk("alarm_mode", 32'(mode), 32'd6);
        chk("alarm_flag", 32'(alarm), 32'd1);
      end
    end
    tick(3);
    press(0);
    chk("alarm_set_ign", 32'(set_p), 32'd0);
    tick(5);
    chk("alarm_hold", 32'(alarm), 32'd1);

    // Reset out of alarm, reprogram, then let a check session time out.
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    chk("rst2_mode", 32'(mode), 32'd0);
    chk("rst2_alarm", 32'(alarm), 32'd0);
    tick(2);
    press(0);
    key(1);
    press(2);
    press(1);
    tick(19);
    chk("chk_timeout_pre", 32'(mode), 32'd2);
    tick(1);
    chk("chk_timeout_mode", 32'(mode), 32'd5);
    chk("chk_timeout_tries", 32'(tries), 32'd1);
    press(0);
    chk("lo_set_ign", 32'(set_p), 32'd0);
    press(1);
    chk("lo_chk_ign", 32'(check_p), 32'd0);
    press(2);
    chk("lo_cfm_ign", 32'(confirm_p), 32'd0);
    tick(6);
    chk("lo_hold", 32'(mode), 32'd5);
    tick(1);
    chk("lo_done", 32'(mode), 32'd0);

    // No verdict within the wait window counts as bad.
    press(1);
    press(2);
    tick(7);
    chk("vw_pre", 32'(mode), 32'd3);
    tick(1);
    chk("vw_mode", 32'(mode), 32'd5);
    chk("vw_tries", 32'(tries), 32'd2);
    tick(10);
    press(1);
    press(2);
    ok_i = 1'b1;
    bad_i = 1'b1;
    tick(1);
    ok_i = 1'b0;
    bad_i = 1'b0;
    chk("okbad_mode", 32'(mode), 32'd6);
    chk("okbad_tries", 32'(tries), 32'd3);
    chk("okbad_unlocked", 32'(unlocked), 32'd0);

    // Reset mid-SETTING with btn_set held through the release.
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    press(0);
    chk("s2_mode", 32'(mode), 32'd1);
    key(1);
    btn_set = 1'b1;
    rst = 1'b1;
    tick(1);
    chk("rst_set_mode", 32'(mode), 32'd0);
    tick(1);
    rst = 1'b0;
    tick(1);
    chk("held_set_p", 32'(set_p), 32'd0);
    tick(3);
    chk("held_mode", 32'(mode), 32'd0);
    btn_set = 1'b0;
    tick(1);
    press(1);
    chk("nopw2_mode", 32'(mode), 32'd0);

    // SETTING timeout, then a key strobe restarting the window.
    press(0);
    tick(19);
    chk("set_to_pre", 32'(mode), 32'd1);
    tick(1);
    chk("set_to_mode", 32'(mode), 32'd0);
    chk("set_to_cfm", 32'(confirm_p), 32'd0);
    press(1);
    chk("set_to_nopw", 32'(mode), 32'd0);
    press(0);
    tick(10);
    key(1);
    tick(19);
    chk("key_ext_pre", 32'(mode), 32'd1);
    tick(1);
    chk("key_ext_end", 32'(mode), 32'd0);
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
